// File: rtl/seq_normalizer.sv
// seq_normalizer
//   Multi-cycle normaliser. A word accepted on the input handshake is
//   shifted left until its MSB is set, using a binary search with one stage
//   per cycle (WIDTH/2, WIDTH/4, ..., 1). The result is the normalised word
//   plus the leading-zero count, so OUT == IN << SHFT. An all-zero input
//   gives OUT=0, SHFT=WIDTH-1 and ZERO=1.
//
// Ports
//   CLK        rising-edge clock
//   N_RST      synchronous reset, active high
//   IN_VALID   IN holds a word to normalise
//   IN_READY   block can accept a word (IDLE only, forced low during reset)
//   IN         word to normalise
//   OUT_VALID  OUT/SHFT/ZERO valid; held until OUT_READY
//   OUT_READY  consumer takes the result
//   OUT        normalised word
//   SHFT       left-shift amount applied (leading zeros of IN)
//   ZERO       IN was all zeros
//
// state  | meaning
// S_IDLE | waiting for a word, IN_READY high
// S_BUSY | one binary-search stage per cycle, step 0..SHW-1
// S_DONE | result presented, waiting for OUT_READY
module seq_normalizer #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic [SHW-1:0]   SHFT,
  output logic             ZERO
);

  localparam logic [SHW-1:0] LAST_STEP = SHW'(SHW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   step, step_nxt;
  logic [SHW-1:0]   count, count_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic             zero_q, zero_nxt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] top_mask;

  always_ff @(posedge CLK) begin
    if (N_RST) begin
      state  <= S_IDLE;
      step   <= '0;
      count  <= '0;
      work   <= '0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      count  <= count_nxt;
      work   <= work_nxt;
      zero_q <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    count_nxt = count;
    work_nxt  = work;
    zero_nxt  = zero_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;

    // Stage width halves each step; top_mask selects the upper shamt bits.
    shamt    = SHW'(WIDTH >> (32'(step) + 32'd1));
    top_mask = ~({WIDTH{1'b1}} >> shamt);

    case (state)
      S_IDLE: begin
        IN_READY = !N_RST;
        if (IN_VALID) begin
          work_nxt  = IN;
          count_nxt = '0;
          zero_nxt  = (IN == '0);
          step_nxt  = '0;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if ((work & top_mask) == '0) begin
          work_nxt  = work << shamt;
          count_nxt = count + shamt;
        end
        if (step == LAST_STEP) begin
          state_nxt = S_DONE;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Results stay visible after the handshake; they only change on the next accept.
  assign OUT  = work;
  assign SHFT = count;
  assign ZERO = zero_q;

`ifdef FORMAL
  logic [WIDTH-1:0] in_cap;

  always_ff @(posedge CLK) begin
    if (N_RST) begin
      in_cap <= '0;
    end else if (state == S_IDLE && IN_VALID) begin
      in_cap <= IN;
    end
  end

  always_comb begin
    if (!N_RST && OUT_VALID) begin
      assert (OUT == (in_cap << SHFT));
      assert (ZERO || OUT[WIDTH-1]);
      assert (!(IN_READY && OUT_VALID));
    end
  end
`endif

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed and random bench for seq_normalizer. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_seq_normalizer;

  logic        CLK = 1'b0;
  logic        N_RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT;
  logic [4:0]  SHFT;
  logic        ZERO;

  int errors = 0;
  int checks = 0;

  seq_normalizer dut (
    .CLK       (CLK),
    .N_RST     (N_RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN        (IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .SHFT      (SHFT),
    .ZERO      (ZERO)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference leading-zero count by linear scan; all-zero maps to 31.
  function automatic logic [4:0] ref_clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 5'(31 - i);
    end
    return 5'd31;
  endfunction

  // Called at a falling edge with the block idle. Presents one word, checks
  // latency and result, optionally stalls OUT_READY for 'hold' cycles, then
  // completes the output handshake.
  task automatic run_word(input logic [31:0] w, input logic [31:0] exp_out,
                          input logic [4:0] exp_shft, input logic exp_zero,
                          input int hold);
    int lat;
    check("ready_before", 32'(IN_READY), 32'd1);
    IN       = w;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN       = $urandom;
    check("ready_busy", 32'(IN_READY), 32'd0);
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
    check("out", OUT, exp_out);
    check("shft", 32'(SHFT), 32'(exp_shft));
    check("zero", 32'(ZERO), 32'(exp_zero));
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      check("hold_valid", 32'(OUT_VALID), 32'd1);
      check("hold_ready", 32'(IN_READY), 32'd0);
      check("hold_out", OUT, exp_out);
      check("hold_shft", 32'(SHFT), 32'(exp_shft));
      check("hold_zero", 32'(ZERO), 32'(exp_zero));
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("valid_drop", 32'(OUT_VALID), 32'd0);
    check("ready_after", 32'(IN_READY), 32'd1);
    check("out_kept", OUT, exp_out);
    check("shft_kept", 32'(SHFT), 32'(exp_shft));
  endtask

  task automatic run_model(input logic [31:0] w);
    logic [4:0] s;
    s = ref_clz(w);
    run_word(w, w << s, s, (w == 32'd0), 0);
  endtask

  initial begin
    logic [31:0] pending;
    logic [31:0] specials [5];
    logic [31:0] w;
    int          last_acc;
    int          results;

    specials[0] = 32'hFFFF_FFFF;
    specials[1] = 32'h7FFF_FFFF;
    specials[2] = 32'h0000_0000;
    specials[3] = 32'h0000_0001;
    specials[4] = 32'h8000_0000;

    N_RST     = 1'b1;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    IN        = 32'h0;
    repeat (2) @(negedge CLK);
    check("rst_out", OUT, 32'h0);
    check("rst_shft", 32'(SHFT), 32'd0);
    check("rst_zero", 32'(ZERO), 32'd0);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_ready_forced", 32'(IN_READY), 32'd0);
    N_RST = 1'b0;
    #1;
    check("ready_after_rst", 32'(IN_READY), 32'd1);
    @(negedge CLK);

    run_word(32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0, 0);
    run_word(32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0, 0);
    run_word(32'h0001_2345, 32'h91A2_8000, 5'd15, 1'b0, 0);
    run_word(32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1, 10);
    run_word(32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd1,  1'b0, 0);

    // Reset while BUSY at step 2: the word is dropped and the block is idle again.
    IN       = 32'h0001_2345;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    N_RST = 1'b1;
    @(negedge CLK);
    check("midrst_valid", 32'(OUT_VALID), 32'd0);
    check("midrst_ready_forced", 32'(IN_READY), 32'd0);
    check("midrst_out", OUT, 32'h0);
    check("midrst_shft", 32'(SHFT), 32'd0);
    N_RST = 1'b0;
    #1;
    check("midrst_ready", 32'(IN_READY), 32'd1);
    run_word(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, 0);
    run_word(32'h0000_0300, 32'hC000_0000, 5'd22, 1'b0, 0);

    // Back-to-back: IN_VALID and OUT_READY held high, IN changes every cycle.
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    IN        = $urandom;
    last_acc  = -1;
    results   = 0;
    pending   = 32'h0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      check("b2b_exclusive", 32'(IN_READY && OUT_VALID), 32'd0);
      if (OUT_VALID) begin
        check("b2b_out", OUT, pending << SHFT);
        check("b2b_shft", 32'(SHFT), 32'(ref_clz(pending)));
        check("b2b_zero", 32'(ZERO), 32'(pending == 32'd0));
        results++;
      end
      if (IN_READY) begin
        if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'd7);
        last_acc = cyc;
        pending  = IN;
      end
      @(negedge CLK);
      IN = $urandom;
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    check("b2b_results", 32'(results), 32'd10);
    @(negedge CLK);

    // Random sweep with single-bit, shifted-random and special words.
    for (int i = 0; i < 3000; i++) begin
      case (i % 4)
        0:       w = 32'd1 << $urandom_range(31, 0);
        1:       w = $urandom;
        2:       w = $urandom >> $urandom_range(31, 0);
        default: w = specials[(i / 4) % 5];
      endcase
      run_model(w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
